// File: rtl/package_param.sv
// rtl/package_param.sv - op classes, RV32I opcodes and FSM states for instr_encoder
package package_param;

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_I     = 4'd1,
    CLS_IL    = 4'd2,
    CLS_S     = 4'd3,
    CLS_B     = 4'd4,
    CLS_JAL   = 4'd5,
    CLS_JALR  = 4'd6,
    CLS_LUI   = 4'd7,
    CLS_AUIPC = 4'd8
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } enc_state_e;

  // IJTYPE is the J-format jump (jal), IITYPE the I-format jump (jalr).
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] ILTYPE = 7'b0000011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] BTYPE  = 7'b1100011;
  localparam logic [6:0] IJTYPE = 7'b1101111;
  localparam logic [6:0] IITYPE = 7'b1100111;
  localparam logic [6:0] U1TYPE = 7'b0110111;
  localparam logic [6:0] U2TYPE = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - scatters the immediate into its RV32I bit positions and range-checks it
module imm_pack
  import package_param::*;
(
  input  logic [3:0]  i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_alt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_range_err
);

  logic signed [31:0] w_simm;
  logic               w_fits12;
  logic               w_fits_b;
  logic               w_fits_j;
  logic               w_shift;

  assign w_simm   = $signed(i_imm);
  assign w_fits12 = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
  assign w_fits_b = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094);
  assign w_fits_j = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574);
  // slli/srli/srai are the only I-class ops with funct3 of 1 or 5
  assign w_shift  = (i_class == CLS_I) && (i_funct3[1:0] == 2'b01);

  always_comb begin
    o_imm_bits  = '0;
    o_range_err = 1'b0;
    case (i_class)
      CLS_I, CLS_IL, CLS_JALR: begin
        if (w_shift) begin
          o_imm_bits  = {1'b0, i_alt, 5'b0, i_imm[4:0], 20'b0};
          o_range_err = (i_imm > 32'd31);
        end else begin
          o_imm_bits  = {i_imm[11:0], 20'b0};
          o_range_err = !w_fits12;
        end
      end
      CLS_S: begin
        o_imm_bits  = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
        o_range_err = !w_fits12;
      end
      CLS_B: begin
        o_imm_bits  = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
        o_range_err = !w_fits_b || i_imm[0];
      end
      CLS_JAL: begin
        o_imm_bits  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
        o_range_err = !w_fits_j || i_imm[0];
      end
      CLS_LUI, CLS_AUIPC: begin
        o_imm_bits  = {i_imm[31:12], 12'b0};
        o_range_err = |i_imm[11:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32I instruction encoder streaming words to imem addresses
module instr_encoder
  import package_param::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_illegal,
  output logic              done,
  output logic              busy
);

  enc_state_e        r_state;
  logic              r_busy;
  logic              r_done;

  logic              r_s1_valid;
  logic [3:0]        r_s1_class;
  logic [2:0]        r_s1_funct3;
  logic              r_s1_alt;
  logic [4:0]        r_s1_rd;
  logic [4:0]        r_s1_rs1;
  logic [4:0]        r_s1_rs2;
  logic [31:0]       r_s1_imm_bits;
  logic              r_s1_illegal;
  logic              r_s1_last;

  logic              r_s2_valid;
  logic              r_s2_last;
  logic [31:0]       r_out_instr;
  logic              r_out_illegal;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_next_addr;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [31:0]       w_imm_bits;
  logic              w_range_err;
  logic              w_field_err;
  logic [31:0]       w_word;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = (r_state == ST_STREAM) && w_s1_adv;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_s2_valid && out_ready;

  imm_pack u_imm_pack (
    .i_class     (in_class),
    .i_funct3    (in_funct3),
    .i_alt       (in_alt),
    .i_imm       (in_imm),
    .o_imm_bits  (w_imm_bits),
    .o_range_err (w_range_err)
  );

  // funct3/alt legality; alt is only meaningful for sub/sra (R) and srai (I)
  always_comb begin
    w_field_err = 1'b0;
    case (in_class)
      CLS_R:    w_field_err = in_alt && (in_funct3 != 3'd0) && (in_funct3 != 3'd5);
      CLS_I:    w_field_err = in_alt && (in_funct3 != 3'd5);
      CLS_IL:   w_field_err = (in_funct3 == 3'd3) || (in_funct3 >= 3'd6);
      CLS_S:    w_field_err = (in_funct3 > 3'd2);
      CLS_B:    w_field_err = (in_funct3 == 3'd2) || (in_funct3 == 3'd3);
      CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC: w_field_err = 1'b0;
      default:  w_field_err = 1'b1;
    endcase
  end

  always_comb begin
    w_word = r_s1_imm_bits;
    case (r_s1_class)
      CLS_R:     w_word = {1'b0, r_s1_alt, 5'b0, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, RTYPE};
      CLS_I:     w_word = r_s1_imm_bits | {12'b0, r_s1_rs1, r_s1_funct3, r_s1_rd, ITYPE};
      CLS_IL:    w_word = r_s1_imm_bits | {12'b0, r_s1_rs1, r_s1_funct3, r_s1_rd, ILTYPE};
      CLS_JALR:  w_word = r_s1_imm_bits | {12'b0, r_s1_rs1, 3'b000, r_s1_rd, IITYPE};
      CLS_S:     w_word = r_s1_imm_bits | {7'b0, r_s1_rs2, r_s1_rs1, r_s1_funct3, 5'b0, STYPE};
      CLS_B:     w_word = r_s1_imm_bits | {7'b0, r_s1_rs2, r_s1_rs1, r_s1_funct3, 5'b0, BTYPE};
      CLS_JAL:   w_word = r_s1_imm_bits | {20'b0, r_s1_rd, IJTYPE};
      CLS_LUI:   w_word = r_s1_imm_bits | {20'b0, r_s1_rd, U1TYPE};
      CLS_AUIPC: w_word = r_s1_imm_bits | {20'b0, r_s1_rd, U2TYPE};
      default:   w_word = NOP_INSTR;
    endcase
    if (r_s1_illegal) begin
      w_word = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_STREAM;
            r_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_in_hs && in_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs && r_s2_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_class    <= '0;
      r_s1_funct3   <= '0;
      r_s1_alt      <= 1'b0;
      r_s1_rd       <= '0;
      r_s1_rs1      <= '0;
      r_s1_rs2      <= '0;
      r_s1_imm_bits <= '0;
      r_s1_illegal  <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s2_last     <= 1'b0;
      r_out_instr   <= '0;
      r_out_illegal <= 1'b0;
      r_out_addr    <= '0;
      r_next_addr   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_hs;
        if (w_in_hs) begin
          r_s1_class    <= in_class;
          r_s1_funct3   <= in_funct3;
          r_s1_alt      <= in_alt;
          r_s1_rd       <= in_rd;
          r_s1_rs1      <= in_rs1;
          r_s1_rs2      <= in_rs2;
          r_s1_imm_bits <= w_imm_bits;
          r_s1_illegal  <= w_range_err || w_field_err;
          r_s1_last     <= in_last;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_instr   <= w_word;
          r_out_illegal <= r_s1_illegal;
          r_s2_last     <= r_s1_last;
          r_out_addr    <= r_next_addr;
        end
      end
      // addresses are bound when a word enters S2, which matches output order
      if ((r_state == ST_IDLE) && start) begin
        r_next_addr <= base_addr;
      end else if (w_s2_adv && r_s1_valid) begin
        r_next_addr <= r_next_addr + ADDR_W'(4);
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_instr   = r_out_instr;
  assign out_addr    = r_out_addr;
  assign out_illegal = r_out_illegal;
  assign done        = r_done;
  assign busy        = r_busy;

endmodule
